// File: rtl/sound_event_arbiter.sv
// -----------------------------------------------------------------------------
// sound_event_arbiter
//
// Upstream sequencer for the audio controller. It captures one-cycle game
// sound events into sticky pending bits, grants them by fixed priority
// (fall > spring > jump), and drives the controller's play request and clip
// select. After each clip it holds a silence gap before the next grant.
// Timeouts recover the block if the controller never starts or never
// finishes a clip.
//
// Parameters
//   GAP_CYCLES    idle cycles held after each clip ends (minimum 1)
//   START_TIMEOUT cycles allowed in START waiting for is_sound_playing
//   PLAY_TIMEOUT  cycles allowed in PLAY waiting for is_sound_done (24-bit)
//
// Ports
//   Clk              system clock
//   Reset            asynchronous, active-high reset
//   ev_jump          one-cycle pulse requesting the jump clip
//   ev_spring        one-cycle pulse requesting the spring clip
//   ev_fall          one-cycle pulse requesting the fall clip
//   mute             level; clears pending requests and blocks new grants
//   is_sound_playing from the controller, high while a clip plays
//   is_sound_done    from the controller, high when a clip has completed
//   play_sound       registered play request to the controller
//   clip_sel         0 none, 1 jump, 2 spring, 3 fall (ROM base-address mux)
//   busy             high in every state except IDLE
//   dropped          saturating count of coalesced events
//   err              saturating count of timeouts
// -----------------------------------------------------------------------------
module sound_event_arbiter #(
    parameter int unsigned GAP_CYCLES    = 1000,
    parameter int unsigned START_TIMEOUT = 1024,
    parameter int unsigned PLAY_TIMEOUT  = 16777215
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       ev_jump,
    input  logic       ev_spring,
    input  logic       ev_fall,
    input  logic       mute,
    input  logic       is_sound_playing,
    input  logic       is_sound_done,
    output logic       play_sound,
    output logic [1:0] clip_sel,
    output logic       busy,
    output logic [7:0] dropped,
    output logic [7:0] err
);

    localparam int TIMER_W = 24;

    // Each wait state leaves on the edge where the timer holds limit-1, so
    // the state lasts exactly "limit" cycles.
    localparam logic [TIMER_W-1:0] GAP_LAST   = TIMER_W'(GAP_CYCLES - 1);
    localparam logic [TIMER_W-1:0] START_LAST = TIMER_W'(START_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] PLAY_LAST  = TIMER_W'(PLAY_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_PLAY  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    state_t             state;
    logic [TIMER_W-1:0] timer;

    // Pending requests, one sticky bit per clip: [0] jump, [1] spring, [2] fall
    logic [2:0] pend;

    logic [2:0] ev_vec;
    logic [2:0] grant_vec;
    logic [1:0] grant_code;
    logic       grant_en;
    logic [2:0] pend_next;
    logic [2:0] drop_vec;

    // Number of set bits in a 3-bit vector (at most 3 coalesced events per cycle).
    function automatic logic [1:0] count_ones3(input logic [2:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

    // Saturating 8-bit accumulate of a small increment.
    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] n);
        logic [8:0] sum;
        sum = {1'b0, a} + {7'd0, n};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    // Saturating 8-bit increment.
    function automatic logic [7:0] sat_inc8(input logic [7:0] a);
        return (a == 8'hFF) ? a : a + 8'd1;
    endfunction

    // Grant decision and pending-bit update. A grant only happens in IDLE
    // while unmuted; the granted bit is cleared unless its own pulse arrives
    // in the same cycle, in which case the new request stays queued and is
    // not counted as coalesced.
    always_comb begin
        ev_vec     = {ev_fall, ev_spring, ev_jump};
        grant_en   = (state == ST_IDLE) && !mute && (pend != 3'b000);
        grant_vec  = 3'b000;
        grant_code = 2'd0;
        if (grant_en) begin
            if (pend[2]) begin
                grant_vec  = 3'b100;
                grant_code = 2'd3;
            end else if (pend[1]) begin
                grant_vec  = 3'b010;
                grant_code = 2'd2;
            end else begin
                grant_vec  = 3'b001;
                grant_code = 2'd1;
            end
        end

        // Mute discards everything, including events that would otherwise
        // have been counted as coalesced.
        if (mute) begin
            pend_next = 3'b000;
            drop_vec  = 3'b000;
        end else begin
            pend_next = ev_vec | (pend & ~grant_vec);
            drop_vec  = ev_vec & pend & ~grant_vec;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pend    <= 3'b000;
            dropped <= 8'd0;
        end else begin
            pend    <= pend_next;
            dropped <= sat_add8(dropped, count_ones3(drop_vec));
        end
    end

    // Sequencer. Every output is registered and written alongside the state
    // transition that changes it; the timer restarts from 0 on each entry.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state      <= ST_IDLE;
            timer      <= '0;
            play_sound <= 1'b0;
            clip_sel   <= 2'd0;
            busy       <= 1'b0;
            err        <= 8'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    timer <= '0;
                    if (grant_en) begin
                        state      <= ST_START;
                        play_sound <= 1'b1;
                        clip_sel   <= grant_code;
                        busy       <= 1'b1;
                    end
                end

                // is_sound_done is deliberately not looked at here: a done
                // level left over from the previous clip must not end this one.
                ST_START: begin
                    if (is_sound_playing) begin
                        state      <= ST_PLAY;
                        timer      <= '0;
                        play_sound <= 1'b0;
                    end else if (timer == START_LAST) begin
                        state      <= ST_GAP;
                        timer      <= '0;
                        play_sound <= 1'b0;
                        clip_sel   <= 2'd0;
                        err        <= sat_inc8(err);
                    end else begin
                        timer <= timer + TIMER_ONE;
                    end
                end

                ST_PLAY: begin
                    if (is_sound_done) begin
                        state    <= ST_GAP;
                        timer    <= '0;
                        clip_sel <= 2'd0;
                    end else if (timer == PLAY_LAST) begin
                        state    <= ST_GAP;
                        timer    <= '0;
                        clip_sel <= 2'd0;
                        err      <= sat_inc8(err);
                    end else begin
                        timer <= timer + TIMER_ONE;
                    end
                end

                ST_GAP: begin
                    if (timer == GAP_LAST) begin
                        state <= ST_IDLE;
                        timer <= '0;
                        busy  <= 1'b0;
                    end else begin
                        timer <= timer + TIMER_ONE;
                    end
                end

                default: begin
                    state      <= ST_IDLE;
                    timer      <= '0;
                    play_sound <= 1'b0;
                    clip_sel   <= 2'd0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sound_event_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sound_event_arbiter
//
// Self-checking bench for sound_event_arbiter with default parameters
// (GAP 1000, START timeout 1024). Directed steps walk the basic flow,
// priority, coalescing, start timeout, mute, async reset and the
// grant-plus-pulse corner; a randomized phase then checks grant order and the
// coalesced-event count against a transaction-level model (pending set plus
// drop tally). Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_sound_event_arbiter;

    localparam int GAP   = 1000;
    localparam int START = 1024;
    localparam int LIMIT = 5000;

    logic       clk;
    logic       reset;
    logic       ev_jump, ev_spring, ev_fall, mute;
    logic       is_sound_playing, is_sound_done;
    logic       play_sound;
    logic [1:0] clip_sel;
    logic       busy;
    logic [7:0] dropped;
    logic [7:0] err;

    int n_total;
    int n_fail;

    sound_event_arbiter dut (
        .Clk              (clk),
        .Reset            (reset),
        .ev_jump          (ev_jump),
        .ev_spring        (ev_spring),
        .ev_fall          (ev_fall),
        .mute             (mute),
        .is_sound_playing (is_sound_playing),
        .is_sound_done    (is_sound_done),
        .play_sound       (play_sound),
        .clip_sel         (clip_sel),
        .busy             (busy),
        .dropped          (dropped),
        .err              (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse(input logic [2:0] v);
        {ev_fall, ev_spring, ev_jump} = v;
        tick();
        {ev_fall, ev_spring, ev_jump} = 3'b000;
    endtask

    // Ticks until play_sound is seen high; n is the number of ticks taken.
    task automatic wait_play(output int n);
        n = 0;
        while (!play_sound && n < LIMIT) begin
            tick();
            n++;
        end
    endtask

    // Counts samples with busy high, starting from the current one.
    task automatic measure_busy(output int n);
        n = 0;
        while (busy && n < LIMIT) begin
            n++;
            tick();
        end
    endtask

    // Controller model: START was just entered; raise is_sound_playing after
    // 'delay' cycles (clearing any stale done level at the same time).
    task automatic start_phase(input int delay);
        repeat (delay) tick();
        chk("start_hold_play", play_sound, 1);
        is_sound_playing = 1'b1;
        is_sound_done    = 1'b0;
        tick();
        chk("play_fall", play_sound, 0);
        chk("play_busy", busy, 1);
    endtask

    // Controller model: finish the clip after 'len' cycles; done stays high as
    // a level until the next clip starts playing.
    task automatic finish_phase(input int len, input logic [1:0] exp_clip);
        repeat (len) tick();
        chk("clip_hold", clip_sel, exp_clip);
        is_sound_playing = 1'b0;
        is_sound_done    = 1'b1;
        tick();
        chk("gap_clip_zero", clip_sel, 0);
        chk("gap_busy", busy, 1);
        chk("gap_play_low", play_sound, 0);
    endtask

    int         n;
    logic [2:0] v;
    int         m_pend[1:3];
    int         m_drop;
    int         exp_clip;

    initial begin
        n_total = 0;
        n_fail  = 0;
        reset = 1'b0;
        {ev_fall, ev_spring, ev_jump} = 3'b000;
        mute = 1'b0;
        is_sound_playing = 1'b0;
        is_sound_done    = 1'b0;

        // ---------------- reset ----------------
        #1 reset = 1'b1;
        #2;
        chk("rst_play", play_sound, 0);
        chk("rst_clip", clip_sel, 0);
        chk("rst_busy", busy, 0);
        chk("rst_dropped", dropped, 0);
        chk("rst_err", err, 0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // ---------------- basic flow ----------------
        pulse(3'b001);
        chk("basic_play_t1", play_sound, 0);
        tick();
        chk("basic_play_t2", play_sound, 1);
        chk("basic_busy_t2", busy, 1);
        chk("basic_clip", clip_sel, 1);
        start_phase(3);
        finish_phase(50, 2'd1);
        measure_busy(n);
        chk("basic_gap_len", n, GAP);
        chk("basic_idle_busy", busy, 0);
        chk("basic_idle_play", play_sound, 0);

        // ---------------- priority ----------------
        pulse(3'b111);
        tick();
        chk("prio_first", clip_sel, 3);
        start_phase(2);
        finish_phase(10, 2'd3);
        wait_play(n);
        chk("prio_gap2", n, GAP + 1);
        chk("prio_second", clip_sel, 2);
        start_phase(2);
        finish_phase(10, 2'd2);
        wait_play(n);
        chk("prio_gap3", n, GAP + 1);
        chk("prio_third", clip_sel, 1);
        start_phase(2);
        finish_phase(10, 2'd1);
        measure_busy(n);
        chk("prio_final_gap", n, GAP);
        chk("prio_dropped", dropped, 0);

        // ---------------- coalescing ----------------
        pulse(3'b100);
        tick();
        chk("coal_fall", clip_sel, 3);
        start_phase(2);
        for (int i = 0; i < 4; i++) begin
            pulse(3'b010);
            tick();
        end
        finish_phase(5, 2'd3);
        chk("coal_dropped_mid", dropped, 3);
        wait_play(n);
        chk("coal_gap", n, GAP + 1);
        chk("coal_spring", clip_sel, 2);
        start_phase(1);
        finish_phase(5, 2'd2);
        measure_busy(n);
        chk("coal_single", n, GAP);
        chk("coal_dropped", dropped, 3);

        // ---------------- start timeout (stale done level held high) ----------------
        chk("to_done_stale", is_sound_done, 1);
        pulse(3'b001);
        tick();
        chk("to_play", play_sound, 1);
        n = 0;
        while (play_sound && n < LIMIT) begin
            tick();
            n++;
        end
        chk("to_start_len", n, START);
        chk("to_err", err, 1);
        chk("to_clip", clip_sel, 0);
        chk("to_busy", busy, 1);
        measure_busy(n);
        chk("to_gap_len", n, GAP);

        // ---------------- mute ----------------
        pulse(3'b001);
        tick();
        chk("mute_jump", clip_sel, 1);
        start_phase(2);
        pulse(3'b100);
        tick();
        mute = 1'b1;
        tick();
        pulse(3'b111);
        tick();
        pulse(3'b100);
        chk("mute_dropped", dropped, 3);
        finish_phase(5, 2'd1);
        repeat (5) tick();
        mute = 1'b0;
        repeat (1100) tick();
        chk("mute_no_grant_busy", busy, 0);
        chk("mute_no_grant_play", play_sound, 0);
        chk("mute_dropped_after", dropped, 3);
        chk("mute_err", err, 1);

        // ---------------- reset mid-PLAY ----------------
        pulse(3'b010);
        tick();
        chk("rp_spring", clip_sel, 2);
        start_phase(2);
        repeat (5) tick();
        #2 reset = 1'b1;
        #1;
        chk("rp_play", play_sound, 0);
        chk("rp_clip", clip_sel, 0);
        chk("rp_busy", busy, 0);
        chk("rp_dropped", dropped, 0);
        chk("rp_err", err, 0);
        is_sound_playing = 1'b0;
        is_sound_done    = 1'b0;
        tick();
        reset = 1'b0;
        tick();

        // ---------------- grant with same-bit pulse ----------------
        ev_jump = 1'b1;
        tick();
        tick();
        ev_jump = 1'b0;
        chk("gp_play", play_sound, 1);
        chk("gp_clip", clip_sel, 1);
        start_phase(1);
        finish_phase(5, 2'd1);
        wait_play(n);
        chk("gp_requeued_gap", n, GAP + 1);
        chk("gp_requeued_clip", clip_sel, 1);
        chk("gp_dropped", dropped, 0);
        start_phase(1);
        finish_phase(5, 2'd1);
        measure_busy(n);
        chk("gp_final_gap", n, GAP);

        // ---------------- randomized grant order / coalescing ----------------
        for (int b = 1; b <= 3; b++) m_pend[b] = 0;
        m_drop = 0;
        for (int r = 0; r < 12; r++) begin
            if (m_pend[1] == 0 && m_pend[2] == 0 && m_pend[3] == 0) begin
                v = 3'($urandom_range(1, 7));
                for (int b = 1; b <= 3; b++)
                    if (v[b-1]) m_pend[b] = 1;
                pulse(v);
            end
            if (m_pend[3] != 0)      exp_clip = 3;
            else if (m_pend[2] != 0) exp_clip = 2;
            else                     exp_clip = 1;
            m_pend[exp_clip] = 0;
            wait_play(n);
            chk("rand_wait_bound", (n < LIMIT), 1);
            chk("rand_grant", clip_sel, exp_clip);
            start_phase($urandom_range(1, 6));
            for (int k = 0; k < 6; k++) begin
                v = 3'($urandom_range(0, 7));
                for (int b = 1; b <= 3; b++)
                    if (v[b-1]) begin
                        if (m_pend[b] != 0) m_drop++;
                        else                m_pend[b] = 1;
                    end
                {ev_fall, ev_spring, ev_jump} = v;
                tick();
            end
            {ev_fall, ev_spring, ev_jump} = 3'b000;
            finish_phase($urandom_range(2, 20), 2'(exp_clip));
            chk("rand_dropped", dropped, m_drop);
        end

        $display("%0d/%0d checks passed", n_total - n_fail, n_total);
        $finish;
    end

endmodule
